// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mc_regfile
// Description : General-purpose register file for the multicycle CPU
//               datapath. It has two combinational read ports and two clocked
//               write ports, where port B wins on a same-address collision.
//               Register 0 is hardwired to zero. Each register also has a
//               pending (scoreboard) bit. The controller sets that bit with
//               bset when an instruction claims the register as its
//               destination. The bit clears automatically when the register
//               is written.
//
// Parameters  : DATA_W  register width in bits
//               ADDR_W  address width, depth = 2**ADDR_W
//
// Ports       : clk                    clock, state updates on rising edge
//               clrn                   asynchronous active-low reset
//               ra1, ra2               read addresses
//               rd1, rd2               read data (combinational)
//               busy1, busy2           pending bit of ra1 / ra2 (combinational)
//               we_a, wa_a, wd_a       write port A (ALU writeback)
//               we_b, wa_b, wd_b       write port B (memory load writeback)
//               bset, bset_addr        mark a register pending
//
// Options     : REGFILE_BYPASS_EN  when defined, the read ports forward
//               same-cycle write data (port B over port A). busyN then shows
//               the value the pending bit will take after the edge. When not
//               defined, the read ports show stored state only.
//
// Revision    : 1.0  initial parametrised release
// ============================================================================
module mc_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              bset,
    input  logic [ADDR_W-1:0] bset_addr
);

    localparam int                c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

    logic [DATA_W-1:0]  r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;

    logic               w_acc_a;
    logic               w_acc_b;
    logic               w_set;
    logic [c_DEPTH-1:0] w_pend_next;

    // A write or set is accepted only out of reset and never for register 0.
    // So register 0 is never written after reset and never marked pending.
    assign w_acc_a = clrn & we_a & (wa_a != c_ZERO_ADDR);
    assign w_acc_b = clrn & we_b & (wa_b != c_ZERO_ADDR);
    assign w_set   = clrn & bset & (bset_addr != c_ZERO_ADDR);

    // Next pending vector. A write clears the bit first and a set is applied
    // last. When both hit the same register, the new producer keeps it busy.
    always_comb begin
        w_pend_next = r_pend;
        if (w_acc_a) begin
            w_pend_next[wa_a] = 1'b0;
        end
        if (w_acc_b) begin
            w_pend_next[wa_b] = 1'b0;
        end
        if (w_set) begin
            w_pend_next[bset_addr] = 1'b1;
        end
    end

    // Storage. Port B is assigned after port A, so B overrides A when both
    // target the same register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_acc_a) begin
                r_regs[wa_a] <= wd_a;
            end
            if (w_acc_b) begin
                r_regs[wa_b] <= wd_b;
            end
            r_pend <= w_pend_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward accepted writes combinationally. Port B has priority.
    // Register 0 is never forwarded because w_acc_* excludes it.
    always_comb begin
        rd1 = r_regs[ra1];
        if (w_acc_b && (wa_b == ra1)) begin
            rd1 = wd_b;
        end else if (w_acc_a && (wa_a == ra1)) begin
            rd1 = wd_a;
        end
    end

    always_comb begin
        rd2 = r_regs[ra2];
        if (w_acc_b && (wa_b == ra2)) begin
            rd2 = wd_b;
        end else if (w_acc_a && (wa_a == ra2)) begin
            rd2 = wd_a;
        end
    end

    assign busy1 = w_pend_next[ra1];
    assign busy2 = w_pend_next[ra2];
`else
    assign rd1   = r_regs[ra1];
    assign rd2   = r_regs[ra2];
    assign busy1 = r_pend[ra1];
    assign busy2 = r_pend[ra2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_regfile
// Description : Self-checking bench for mc_regfile. It uses a 32x32 instance
//               with directed and random stimulus checked against an array
//               model, plus a 16-bit x 8 instance for the parameter sweep.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_regfile;

    logic        clk;
    logic        clrn;
    logic [4:0]  ra1, ra2, wa_a, wa_b, bset_addr;
    logic [31:0] rd1, rd2, wd_a, wd_b;
    logic        busy1, busy2, we_a, we_b, bset;

    logic [2:0]  s_ra1, s_ra2, s_wa_a, s_wa_b, s_bset_addr;
    logic [15:0] s_rd1, s_rd2, s_wd_a, s_wd_b;
    logic        s_busy1, s_busy2, s_we_a, s_we_b, s_bset;

    int n_checks;
    int n_errors;

    logic [31:0] m_reg  [32];
    logic        m_pend [32];
    logic [15:0] s_m    [8];

    mc_regfile #(.DATA_W(32), .ADDR_W(5)) u_dut (
        .clk(clk), .clrn(clrn),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .bset(bset), .bset_addr(bset_addr)
    );

    mc_regfile #(.DATA_W(16), .ADDR_W(3)) u_dut_s (
        .clk(clk), .clrn(clrn),
        .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
        .busy1(s_busy1), .busy2(s_busy2),
        .we_a(s_we_a), .wa_a(s_wa_a), .wd_a(s_wd_a),
        .we_b(s_we_b), .wa_b(s_wa_b), .wd_b(s_wd_b),
        .bset(s_bset), .bset_addr(s_bset_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'h0 : m_reg[ra];
`ifdef REGFILE_BYPASS_EN
        if (clrn && ra != 5'd0) begin
            if (we_b && wa_b == ra)      v = wd_b;
            else if (we_a && wa_a == ra) v = wd_a;
        end
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        logic b;
        b = (ra == 5'd0) ? 1'b0 : m_pend[ra];
`ifdef REGFILE_BYPASS_EN
        if (clrn && ra != 5'd0) begin
            if (bset && bset_addr == ra)                            b = 1'b1;
            else if ((we_a && wa_a == ra) || (we_b && wa_b == ra))  b = 1'b0;
        end
`endif
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (clrn) begin
            if (we_a && wa_a != 5'd0) begin
                m_reg[wa_a]  = wd_a;
                m_pend[wa_a] = 1'b0;
            end
            if (we_b && wa_b != 5'd0) begin
                m_reg[wa_b]  = wd_b;
                m_pend[wa_b] = 1'b0;
            end
            if (bset && bset_addr != 5'd0) m_pend[bset_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        bset = 1'b0; bset_addr = '0;
    endtask

    // Entered just after a rising edge with the inputs already driven.
    // Checks the combinational outputs, then applies the edge to the model.
    task automatic tick(input string tag);
        #1;
        chk({tag, ".rd1"},   rd1,        exp_rd(ra1));
        chk({tag, ".rd2"},   rd2,        exp_rd(ra2));
        chk({tag, ".busy1"}, 32'(busy1), 32'(exp_busy(ra1)));
        chk({tag, ".busy2"}, 32'(busy2), 32'(exp_busy(ra2)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        clrn = 1'b0;
        idle();
        ra1 = 5'd5; ra2 = 5'd0;
        s_we_a = 1'b0; s_wa_a = '0; s_wd_a = '0;
        s_we_b = 1'b0; s_wa_b = '0; s_wd_b = '0;
        s_bset = 1'b0; s_bset_addr = '0; s_ra1 = '0; s_ra2 = '0;
        model_reset();
        for (int i = 0; i < 8; i++) s_m[i] = 16'h0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rd1",   rd1,        32'h0);
        chk("rst.busy1", 32'(busy1), 32'h0);
        clrn = 1'b1;

        // ---- zero register ----
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF;
        bset = 1'b1; bset_addr = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
        tick("zero");
        idle();
        #1;
        chk("zero.rd1",   rd1,        32'h0);
        chk("zero.busy1", 32'(busy1), 32'h0);

        // ---- dual write conflict ----
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hAAAA_0000;
        we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h0000_BBBB;
        ra2 = 5'd7;
        tick("dual");
        idle();
        #1;
        chk("dual.rd2", rd2, 32'h0000_BBBB);

        // ---- scoreboard ----
        ra1 = 5'd9;
        bset = 1'b1; bset_addr = 5'd9;
        tick("sb.set");
        idle();
        #1;
        chk("sb.set.busy1", 32'(busy1), 32'h1);
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h55;
        tick("sb.wr");
        idle();
        #1;
        chk("sb.wr.busy1", 32'(busy1), 32'h0);
        chk("sb.wr.rd1",   rd1,        32'h55);
        bset = 1'b1; bset_addr = 5'd9;
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h0BAD_F00D;
        tick("sb.both");
        idle();
        #1;
        chk("sb.both.busy1", 32'(busy1), 32'h1);
        chk("sb.both.rd1",   rd1,        32'h0BAD_F00D);

        // ---- write-to-read in the same cycle ----
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h11;
        tick("byp.pre");
        idle();
        ra1 = 5'd3;
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hDEAD_BEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp.same", rd1, 32'hDEAD_BEEF);
`else
        chk("byp.same", rd1, 32'h11);
`endif
        tick("byp");
        idle();
        #1;
        chk("byp.next", rd1, 32'hDEAD_BEEF);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 300; n++) begin
            ra1  = rnd_addr();
            ra2  = rnd_addr();
            we_a = 1'($urandom_range(0, 1));
            wa_a = rnd_addr();
            wd_a = $urandom();
            we_b = 1'($urandom_range(0, 1));
            wa_b = ($urandom_range(0, 3) == 0) ? wa_a : rnd_addr();
            wd_b = $urandom();
            bset = 1'($urandom_range(0, 1));
            bset_addr = ($urandom_range(0, 3) == 0) ? wa_a : rnd_addr();
            tick("rnd");
        end
        idle();

        // ---- parameter sweep on the 16-bit x 8 instance ----
        for (int i = 0; i < 8; i++) begin
            s_we_a = 1'b1; s_wa_a = 3'(i); s_wd_a = 16'(16'hA000 + i * 16'h0111);
            @(posedge clk);
            if (i != 0) s_m[i] = s_wd_a;
            #1;
        end
        s_we_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_ra1 = 3'(i); s_ra2 = 3'(7 - i);
            #1;
            chk("sweep.rd1",   32'(s_rd1),   32'(s_m[i]));
            chk("sweep.rd2",   32'(s_rd2),   32'(s_m[7 - i]));
            chk("sweep.busy1", 32'(s_busy1), 32'h0);
        end
        chk("sweep.r0", 32'(s_m[0]) | 32'(s_rd1 & 16'h0), 32'h0);
        s_ra1 = 3'd0;
        #1;
        chk("sweep.rd_r0", 32'(s_rd1), 32'h0);

        // ---- asynchronous reset mid-cycle ----
        @(posedge clk);
        #1;
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234_5678;
        bset = 1'b1; bset_addr = 5'd5;
        ra1 = 5'd5;
        tick("ar.load");
        idle();
        #1;
        chk("ar.pre.rd1",   rd1,        32'h1234_5678);
        chk("ar.pre.busy1", 32'(busy1), 32'h1);
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hCAFE_0000;
        #1;
        clrn = 1'b0;
        model_reset();
        #1;
        chk("ar.rd1",   rd1,        32'h0);
        chk("ar.busy1", 32'(busy1), 32'h0);
        @(posedge clk);
        #1;
        chk("ar.hold.rd1", rd1, 32'h0);
        idle();
        clrn = 1'b1;
        #1;
        chk("ar.post.rd1", rd1, 32'h0);
        we_b = 1'b1; wa_b = 5'd5; wd_b = 32'h0000_7777;
        tick("ar.first");
        idle();
        #1;
        chk("ar.first.rd1", rd1, 32'h0000_7777);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
